// File: rtl/camera_patrol_ctrl.sv
// Security-camera patrol controller: pans between two X limits, dwells at each end and
// raises a timed alert after a debounced player sighting, then resumes where it left off.
module camera_patrol_ctrl #(
   parameter logic [9:0] LEFT_LIMIT    = 10'd40,
   parameter logic [9:0] RIGHT_LIMIT   = 10'd600,
   parameter logic [7:0] DWELL_FRAMES  = 8'd60,
   parameter logic [7:0] ALERT_FRAMES  = 8'd120,
   parameter logic [3:0] DETECT_FRAMES = 4'd3
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       enable,
   input  logic [9:0] camX,
   input  logic       player_in_view,
   output logic [1:0] direction_cam,
   output logic       alert,
   output logic [7:0] alert_count,
   output logic [2:0] patrol_state
);

   typedef enum logic [2:0] {
      StInit   = 3'd0,
      StPanR   = 3'd1,
      StDwellR = 3'd2,
      StPanL   = 3'd3,
      StDwellL = 3'd4,
      StAlert  = 3'd5
   } state_e;

   // Zero-length windows are treated as one frame so the terminal compare cannot wrap.
   localparam logic [7:0] DwellLast = (DWELL_FRAMES == 8'd0) ? 8'd0 : DWELL_FRAMES - 8'd1;
   localparam logic [7:0] AlertLast = (ALERT_FRAMES == 8'd0) ? 8'd0 : ALERT_FRAMES - 8'd1;
   localparam logic [3:0] SeenLast  = (DETECT_FRAMES == 4'd0) ? 4'd0 : DETECT_FRAMES - 4'd1;

   state_e     state_q, state_d;
   state_e     resume_q, resume_d;
   logic [7:0] dwell_cnt_q, dwell_cnt_d;
   logic [7:0] alert_cnt_q, alert_cnt_d;
   logic [7:0] alert_count_q, alert_count_d;
   logic [3:0] seen_cnt_q, seen_cnt_d;
   logic       detect;
   logic       at_right;
   logic       at_left;
   logic       enter_alert;

   assign detect   = player_in_view && (seen_cnt_q == SeenLast);
   assign at_right = (camX >= RIGHT_LIMIT);
   assign at_left  = (camX <= LEFT_LIMIT);

   always_comb begin
      state_d       = state_q;
      resume_d      = resume_q;
      dwell_cnt_d   = dwell_cnt_q;
      alert_cnt_d   = alert_cnt_q;
      alert_count_d = alert_count_q;
      enter_alert   = 1'b0;

      if (!player_in_view) begin
         seen_cnt_d = 4'd0;
      end else if (seen_cnt_q < DETECT_FRAMES) begin
         seen_cnt_d = seen_cnt_q + 4'd1;
      end else begin
         seen_cnt_d = seen_cnt_q;
      end

      if (!enable) begin
         state_d     = StInit;
         dwell_cnt_d = 8'd0;
         alert_cnt_d = 8'd0;
         seen_cnt_d  = 4'd0;
      end else begin
         unique case (state_q)
            StInit: state_d = StPanR;
            StPanR: begin
               // A sighting beats the limit; the limit is remembered via resume_d.
               if (detect) begin
                  enter_alert = 1'b1;
                  resume_d    = at_right ? StDwellR : StPanR;
               end else if (at_right) begin
                  state_d     = StDwellR;
                  dwell_cnt_d = 8'd0;
               end
            end
            StPanL: begin
               if (detect) begin
                  enter_alert = 1'b1;
                  resume_d    = at_left ? StDwellL : StPanL;
               end else if (at_left) begin
                  state_d     = StDwellL;
                  dwell_cnt_d = 8'd0;
               end
            end
            StDwellR: begin
               if (detect) begin
                  enter_alert = 1'b1;
                  resume_d    = StDwellR;
               end else if (dwell_cnt_q == DwellLast) begin
                  state_d = StPanL;
               end else begin
                  dwell_cnt_d = dwell_cnt_q + 8'd1;
               end
            end
            StDwellL: begin
               if (detect) begin
                  enter_alert = 1'b1;
                  resume_d    = StDwellL;
               end else if (dwell_cnt_q == DwellLast) begin
                  state_d = StPanR;
               end else begin
                  dwell_cnt_d = dwell_cnt_q + 8'd1;
               end
            end
            StAlert: begin
               if (player_in_view) begin
                  alert_cnt_d = 8'd0;
               end else if (alert_cnt_q == AlertLast) begin
                  state_d     = resume_q;
                  dwell_cnt_d = 8'd0;
               end else begin
                  alert_cnt_d = alert_cnt_q + 8'd1;
               end
            end
            default: state_d = StInit;
         endcase

         if (enter_alert) begin
            state_d     = StAlert;
            alert_cnt_d = 8'd0;
            if (alert_count_q != 8'hFF) begin
               alert_count_d = alert_count_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q       <= StInit;
         resume_q      <= StPanR;
         dwell_cnt_q   <= 8'd0;
         alert_cnt_q   <= 8'd0;
         alert_count_q <= 8'd0;
         seen_cnt_q    <= 4'd0;
      end else begin
         state_q       <= state_d;
         resume_q      <= resume_d;
         dwell_cnt_q   <= dwell_cnt_d;
         alert_cnt_q   <= alert_cnt_d;
         alert_count_q <= alert_count_d;
         seen_cnt_q    <= seen_cnt_d;
      end
   end

   always_comb begin
      unique case (state_q)
         StPanL:  direction_cam = 2'b00;
         StPanR:  direction_cam = 2'b01;
         default: direction_cam = 2'b11;
      endcase
   end

   assign alert        = (state_q == StAlert);
   assign alert_count  = alert_count_q;
   assign patrol_state = state_q;

endmodule

// File: tb/tb_camera_patrol_ctrl.sv
// Directed bench for camera_patrol_ctrl: each step drives one frame of inputs, queues the
// expected outputs and compares them against the DUT just after the frame edge.
module tb_camera_patrol_ctrl;

   localparam logic [2:0] SI  = 3'd0;
   localparam logic [2:0] SR  = 3'd1;
   localparam logic [2:0] SDR = 3'd2;
   localparam logic [2:0] SL  = 3'd3;
   localparam logic [2:0] SDL = 3'd4;
   localparam logic [2:0] SA  = 3'd5;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       enable;
   logic [9:0] camX;
   logic       player_in_view;
   logic [1:0] direction_cam;
   logic       alert;
   logic [7:0] alert_count;
   logic [2:0] patrol_state;

   typedef struct {
      string      tag;
      logic [1:0] dir;
      logic [2:0] st;
      logic       al;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] exp_cnt  = 8'd0;
   logic [2:0] prev_st  = SI;

   camera_patrol_ctrl #(
      .LEFT_LIMIT   (10'd40),
      .RIGHT_LIMIT  (10'd600),
      .DWELL_FRAMES (8'd4),
      .ALERT_FRAMES (8'd5),
      .DETECT_FRAMES(4'd3)
   ) dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .enable        (enable),
      .camX          (camX),
      .player_in_view(player_in_view),
      .direction_cam (direction_cam),
      .alert         (alert),
      .alert_count   (alert_count),
      .patrol_state  (patrol_state)
   );

   always #5 frame_clk = ~frame_clk;

   function automatic logic [1:0] dir_of(input logic [2:0] st);
      if (st == SL) return 2'b00;
      if (st == SR) return 2'b01;
      return 2'b11;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic en, input logic [9:0] x,
                       input logic piv, input logic [2:0] st);
      exp_t e;
      Reset          = rst;
      enable         = en;
      camX           = x;
      player_in_view = piv;
      if (rst) exp_cnt = 8'd0;
      else if (st == SA && prev_st != SA && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      prev_st = st;
      e.tag = tag;
      e.dir = dir_of(st);
      e.st  = st;
      e.al  = (st == SA);
      e.cnt = exp_cnt;
      sb_q.push_back(e);
      @(posedge frame_clk);
      #1;
      e = sb_q.pop_front();
      check({e.tag, ".state"}, {5'd0, patrol_state}, {5'd0, e.st});
      check({e.tag, ".dir"}, {6'd0, direction_cam}, {6'd0, e.dir});
      check({e.tag, ".alert"}, {7'd0, alert}, {7'd0, e.al});
      check({e.tag, ".count"}, alert_count, e.cnt);
   endtask

   task automatic steps(input string tag, input int n, input logic en, input logic [9:0] x,
                        input logic piv, input logic [2:0] st);
      for (int i = 0; i < n; i++) step(tag, 1'b0, en, x, piv, st);
   endtask

   initial begin
      Reset = 1'b1; enable = 1'b1; camX = 10'd300; player_in_view = 1'b0;
      // reset and patrol start
      step("reset1", 1, 1, 300, 0, SI);
      step("reset2", 1, 1, 300, 0, SI);
      step("start", 0, 1, 300, 0, SR);
      step("pan_r", 0, 1, 300, 0, SR);
      // right and left limits with dwell
      step("r_limit", 0, 1, 600, 0, SDR);
      steps("dwell_r", 3, 1, 600, 0, SDR);
      step("to_pan_l", 0, 1, 600, 0, SL);
      step("pan_l", 0, 1, 300, 0, SL);
      step("l_limit", 0, 1, 40, 0, SDL);
      steps("dwell_l", 3, 1, 40, 0, SDL);
      step("to_pan_r", 0, 1, 40, 0, SR);
      step("r_limit2", 0, 1, 600, 0, SDR);
      steps("dwell_r2", 3, 1, 600, 0, SDR);
      step("to_pan_l2", 0, 1, 300, 0, SL);
      // debounce 1,1,0,1,1,1
      step("db1", 0, 1, 300, 1, SL);
      step("db2", 0, 1, 300, 1, SL);
      step("db3", 0, 1, 300, 0, SL);
      step("db4", 0, 1, 300, 1, SL);
      step("db5", 0, 1, 300, 1, SL);
      step("db6", 0, 1, 300, 1, SA);
      steps("alert_hold", 4, 1, 300, 0, SA);
      step("resume_l", 0, 1, 300, 0, SL);
      // re-arm at alert_cnt=3
      step("arm1", 0, 1, 300, 1, SL);
      step("arm2", 0, 1, 300, 1, SL);
      step("arm3", 0, 1, 300, 1, SA);
      steps("arm_cnt", 3, 1, 300, 0, SA);
      step("pulse", 0, 1, 300, 1, SA);
      steps("post_pulse", 4, 1, 300, 0, SA);
      step("rearm_exit", 0, 1, 300, 0, SL);
      // limit and detection on the same edge
      step("to_dl", 0, 1, 40, 0, SDL);
      steps("dl_hold", 3, 1, 40, 0, SDL);
      step("pan_r3", 0, 1, 300, 0, SR);
      step("sim1", 0, 1, 300, 1, SR);
      step("sim2", 0, 1, 300, 1, SR);
      step("sim3", 0, 1, 600, 1, SA);
      steps("sim_alert", 4, 1, 600, 0, SA);
      step("res_dwell", 0, 1, 600, 0, SDR);
      steps("res_dwell_hold", 3, 1, 600, 0, SDR);
      step("after_dwell", 0, 1, 600, 0, SL);
      // disable mid-alert
      step("da1", 0, 1, 300, 1, SL);
      step("da2", 0, 1, 300, 1, SL);
      step("da3", 0, 1, 300, 1, SA);
      step("disable", 0, 0, 300, 0, SI);
      step("disabled", 0, 0, 300, 0, SI);
      // seen_cnt counts during the INIT frame
      step("init_seen", 0, 1, 300, 1, SR);
      step("seen2", 0, 1, 300, 1, SR);
      step("seen3", 0, 1, 300, 1, SA);
      steps("seen_alert", 4, 1, 300, 0, SA);
      step("res_r", 0, 1, 300, 0, SR);
      // reset mid-alert and mid-dwell
      step("ra1", 0, 1, 300, 1, SR);
      step("ra2", 0, 1, 300, 1, SR);
      step("ra3", 0, 1, 300, 1, SA);
      step("rst_alert", 1, 1, 300, 0, SI);
      step("restart", 0, 1, 300, 0, SR);
      step("rd1", 0, 1, 600, 0, SDR);
      step("rd2", 0, 1, 600, 0, SDR);
      step("rst_dwell", 1, 1, 600, 0, SI);
      step("restart2", 0, 1, 300, 0, SR);
      // alert_count saturation
      for (int k = 0; k < 257; k++) begin
         step("sat_a", 0, 1, 300, 1, SR);
         step("sat_b", 0, 1, 300, 1, SR);
         step("sat_alert", 0, 1, 300, 1, SA);
         step("sat_dis", 0, 0, 300, 0, SI);
         step("sat_en", 0, 1, 300, 0, SR);
      end
      check("sat_final", alert_count, 8'd255);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
